regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, 32, data width in bits.
REQ-002 Parameter NREG, 32, number of architectural registers (power of two, >=2); AW = clog2(NREG).
REQ-003 Parameter NRP, 2, number of read ports (1..4).
REQ-004 Parameter FWD, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = disabled.
REQ-005 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-006 The design SHALL use one clock, clk; reset is synchronous and active-low, rst_n.
REQ-007 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- we  in  1  register write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- ra  in  NRP*AW  packed read addresses; port i uses bits [i*AW +: AW]
- rd  out  NRP*XLEN  packed read data
- rd_busy  out  NRP  per-port "source register pending" flag
- iss_v  in  1  issue strobe; marks iss_rd as pending
- iss_rd  in  AW  destination being issued
- flush  in  1  clear all pending flags
- pc_we  in  1  PC write enable
- pc_in  in  XLEN  next PC
- pc_out  out  XLEN  current PC
- busy_cnt  out  AW+1  number of registers currently pending

Function
REQ-008 Register 0 SHALL always read 0; writes and issues to address 0 SHALL be ignored.
REQ-009 Writes SHALL commit on the rising edge of clk when we=1 and wa!=0.
REQ-010 Reads SHALL be combinational: rd[i] = x[ra[i]], with zero latency.
REQ-011 With FWD=1, if we=1, wa!=0 and wa==ra[i], rd[i] SHALL equal wd in the same cycle; with FWD=0, rd[i] SHALL show the old value.
REQ-012 Each register SHALL have a busy bit, set at the clock edge when iss_v=1 and iss_rd!=0.
REQ-013 A busy bit SHALL clear at the clock edge when we=1 and wa matches its address.
REQ-014 If a set (iss_v) and a clear (we) hit the same register in one cycle, set SHALL win; the bit ends at 1.
REQ-015 Issuing to a register that is already busy SHALL leave it busy, with no error; there is no outstanding-count per register.
REQ-016 rd_busy[i] = busy[ra[i]]; with FWD=1 it SHALL be forced to 0 when a same-cycle write hits ra[i]. An issue in the current cycle is not visible until the next cycle.
REQ-017 flush=1 SHALL clear every busy bit at the edge. It SHALL take priority over iss_v in the same cycle. A concurrent we still commits its data.
REQ-018 busy_cnt SHALL equal the population count of the busy bits, registered and updated in the same edge as the bits; maximum value NREG-1.
REQ-019 pc_out SHALL load pc_in at the edge when pc_we=1, and hold otherwise.
REQ-020 Simultaneous we, iss_v and pc_we SHALL all take effect independently, subject to REQ-014 and REQ-017.

Reset
REQ-021 When rst_n=0 at an edge, the block SHALL set every register to 0, every busy bit to 0, busy_cnt to 0 and pc_out to RESET_PC.
REQ-022 Reset SHALL dominate we, iss_v, flush and pc_we in that cycle.
REQ-023 Combinational read outputs SHALL reflect the post-reset state from the cycle after reset.

Structure
REQ-024 Shared package regfile_pkg SHALL hold the default XLEN, NREG and RESET_PC values and the AW derivation function.
REQ-025 The busy-bit array, its set/clear/flush priority logic and busy_cnt SHALL live in sub-module regfile_scoreboard; regfile_sb instantiates it once.
REQ-026 The storage array SHALL be flip-flop based so that NRP asynchronous read ports are possible.

Verification
REQ-027 Reset then read all ports -> rd=0, rd_busy=0, busy_cnt=0, pc_out=RESET_PC.
REQ-028 Write x5=0xDEADBEEF with ra0=5 in the same cycle -> FWD=1: rd0=0xDEADBEEF that cycle; FWD=0: rd0=0 that cycle and 0xDEADBEEF next.
REQ-029 Write x0=0x1234, then issue to x0 -> rd=0 on x0, busy_cnt stays 0.
REQ-030 Issue x7; next cycle ra1=7 -> rd_busy1=1, busy_cnt=1; then we to x7=0x55 -> rd_busy1=0 that cycle (FWD=1) and busy_cnt=0 after the edge.
REQ-031 iss_v x9 and we x9 in the same cycle -> x9 holds the write data and stays busy; then iss_v x3 with flush=1 -> all busy bits 0, busy_cnt=0.
REQ-032 pc_we=1, pc_in=0x100 while rst_n=0 -> pc_out=RESET_PC; next cycle with rst_n=1 -> pc_out=0x100.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared defaults and width helpers for the scoreboarded
//             register file (regfile_sb and regfile_scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default configuration values used by the register file parameters.
    localparam int          c_DEF_XLEN     = 32;
    localparam int          c_DEF_NREG     = 32;
    localparam logic [63:0] c_DEF_RESET_PC = 64'h0;

    // Address width for a power-of-two register count (NREG >= 2).
    function automatic int calc_aw(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Per-register busy bits with set/clear/flush priority and a
//             registered population count of the pending registers.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int   NREG = c_DEF_NREG,
    localparam int  AW   = calc_aw(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_nxt;

    // Next busy vector: flush clears everything and blocks issue; otherwise
    // the write-back clear is applied first so a same-register issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (we && (wa != '0)) begin
                w_busy_nxt[wa] = 1'b0;
            end
            if (iss_v && (iss_rd != '0)) begin
                w_busy_nxt[iss_rd] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Population count of the next busy vector so the count tracks the bits.
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    // Busy bits and their count update together on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Flip-flop register file with NRP combinational read ports,
//             optional write-to-read forwarding, a busy-bit scoreboard and
//             a program counter register.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int               XLEN     = c_DEF_XLEN,
    parameter int               NREG     = c_DEF_NREG,
    parameter int               NRP      = 2,
    parameter int               FWD      = 1,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(c_DEF_RESET_PC),
    localparam int              AW       = calc_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRP*AW-1:0]   ra,
    output logic [NRP*XLEN-1:0] rd,
    output logic [NRP-1:0]      rd_busy,
    input  logic                iss_v,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    input  logic                pc_we,
    input  logic [XLEN-1:0]     pc_in,
    output logic [XLEN-1:0]     pc_out,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] r_pc;
    logic [NREG-1:0] w_busy;
    logic            w_wr_en;

    // x0 is hardwired to zero, so writes to it never take effect.
    assign w_wr_en = we && (wa != '0);

    // Register storage; x0 stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wa] <= wd;
        end
    end

    // Program counter: load on pc_we, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (pc_we) begin
            r_pc <= pc_in;
        end
    end

    assign pc_out = r_pc;

    regfile_scoreboard #(
        .NREG     (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .iss_v    (iss_v),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    // One combinational read port per lane; a same-cycle write to the read
    // address bypasses storage and masks the busy flag when forwarding is on.
    generate
        for (genvar g = 0; g < NRP; g++) begin : g_rp
            logic [AW-1:0] w_ra;
            logic          w_hit;

            assign w_ra  = ra[g*AW +: AW];
            assign w_hit = (FWD != 0) && w_wr_en && (wa == w_ra);

            assign rd[g*XLEN +: XLEN] = w_hit          ? wd :
                                        (w_ra == '0)   ? '0 :
                                                         r_regs[w_ra];
            assign rd_busy[g]         = w_hit ? 1'b0 : w_busy[w_ra];
        end
    endgenerate

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Directed self-checking bench for regfile_sb; one instance with
//             forwarding and one without, sharing all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int          XLEN = 32;
    localparam int          NREG = 32;
    localparam int          NRP  = 2;
    localparam int          AW   = 5;
    localparam logic [31:0] c_RPC = 32'h0000_0080;

    logic                clk;
    logic                rst_n;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic [NRP*AW-1:0]   ra;
    logic                iss_v;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic                pc_we;
    logic [XLEN-1:0]     pc_in;

    logic [NRP*XLEN-1:0] rd;
    logic [NRP-1:0]      rd_busy;
    logic [XLEN-1:0]     pc_out;
    logic [AW:0]         busy_cnt;

    logic [NRP*XLEN-1:0] rd_nf;
    logic [NRP-1:0]      rd_busy_nf;
    logic [XLEN-1:0]     pc_out_nf;
    logic [AW:0]         busy_cnt_nf;

    int total = 0;
    int bad   = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .FWD(1), .RESET_PC(c_RPC)) u_dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
        .rd_busy(rd_busy), .iss_v(iss_v), .iss_rd(iss_rd), .flush(flush),
        .pc_we(pc_we), .pc_in(pc_in), .pc_out(pc_out), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .FWD(0), .RESET_PC(c_RPC)) u_dut_nf (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nf),
        .rd_busy(rd_busy_nf), .iss_v(iss_v), .iss_rd(iss_rd), .flush(flush),
        .pc_we(pc_we), .pc_in(pc_in), .pc_out(pc_out_nf), .busy_cnt(busy_cnt_nf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_rd = '0;
        flush = 1'b0; pc_we = 1'b0; pc_in = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); ra = {5'd7, 5'd5};
        tick(); tick();
        rst_n = 1'b1;
        #1;
        total++; if (rd !== 64'h0) begin bad++; $display("FAIL reset_rd got=%h exp=%h", rd, 64'h0); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_rd_busy got=%b exp=%b", rd_busy, 2'b00); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_busy_cnt got=%0d exp=%0d", busy_cnt, 0); end
        total++; if (pc_out !== c_RPC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_out, c_RPC); end
    endtask

    task automatic test_forward();
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra = {5'd0, 5'd5};
        #1;
        total++; if (rd[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fwd_same_cycle got=%h exp=%h", rd[31:0], 32'hDEAD_BEEF); end
        total++; if (rd_nf[31:0] !== 32'h0) begin bad++; $display("FAIL nofwd_same_cycle got=%h exp=%h", rd_nf[31:0], 32'h0); end
        tick();
        idle();
        #1;
        total++; if (rd[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fwd_next_cycle got=%h exp=%h", rd[31:0], 32'hDEAD_BEEF); end
        total++; if (rd_nf[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL nofwd_next_cycle got=%h exp=%h", rd_nf[31:0], 32'hDEAD_BEEF); end
    endtask

    task automatic test_x0();
        we = 1'b1; wa = 5'd0; wd = 32'h0000_1234; ra = {5'd5, 5'd0};
        #1;
        total++; if (rd[31:0] !== 32'h0) begin bad++; $display("FAIL x0_no_fwd got=%h exp=%h", rd[31:0], 32'h0); end
        tick();
        idle(); iss_v = 1'b1; iss_rd = 5'd0;
        tick();
        idle();
        #1;
        total++; if (rd[31:0] !== 32'h0) begin bad++; $display("FAIL x0_read got=%h exp=%h", rd[31:0], 32'h0); end
        total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL x0_busy got=%b exp=%b", rd_busy[0], 1'b0); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL x0_busy_cnt got=%0d exp=%0d", busy_cnt, 0); end
    endtask

    task automatic test_busy_clear();
        iss_v = 1'b1; iss_rd = 5'd7; ra = {5'd7, 5'd5};
        #1;
        total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL issue_not_visible got=%b exp=%b", rd_busy[1], 1'b0); end
        tick();
        idle();
        #1;
        total++; if (rd_busy[1] !== 1'b1) begin bad++; $display("FAIL issued_busy got=%b exp=%b", rd_busy[1], 1'b1); end
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL issued_cnt got=%0d exp=%0d", busy_cnt, 1); end
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0055;
        #1;
        total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL wb_busy_fwd got=%b exp=%b", rd_busy[1], 1'b0); end
        total++; if (rd_busy_nf[1] !== 1'b1) begin bad++; $display("FAIL wb_busy_nofwd got=%b exp=%b", rd_busy_nf[1], 1'b1); end
        total++; if (rd[63:32] !== 32'h55) begin bad++; $display("FAIL wb_data_fwd got=%h exp=%h", rd[63:32], 32'h55); end
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL wb_cnt got=%0d exp=%0d", busy_cnt, 0); end
        total++; if (rd_busy_nf[1] !== 1'b0) begin bad++; $display("FAIL wb_busy_after got=%b exp=%b", rd_busy_nf[1], 1'b0); end
        total++; if (rd_nf[63:32] !== 32'h55) begin bad++; $display("FAIL wb_data_after got=%h exp=%h", rd_nf[63:32], 32'h55); end
    endtask

    task automatic test_set_wins_flush();
        iss_v = 1'b1; iss_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'hA5A5_0009; ra = {5'd3, 5'd9};
        tick();
        idle();
        #1;
        total++; if (rd[31:0] !== 32'hA5A5_0009) begin bad++; $display("FAIL setwin_data got=%h exp=%h", rd[31:0], 32'hA5A5_0009); end
        total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL setwin_busy got=%b exp=%b", rd_busy[0], 1'b1); end
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL setwin_cnt got=%0d exp=%0d", busy_cnt, 1); end
        iss_v = 1'b1; iss_rd = 5'd3;
        tick();
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== 6'd2) begin bad++; $display("FAIL reissue_cnt got=%0d exp=%0d", busy_cnt, 2); end
        total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL reissue_busy got=%b exp=%b", rd_busy, 2'b11); end
        iss_v = 1'b1; iss_rd = 5'd12; flush = 1'b1; we = 1'b1; wa = 5'd20; wd = 32'h2020_2020;
        tick();
        idle(); ra = {5'd20, 5'd12};
        #1;
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", busy_cnt, 0); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL flush_busy got=%b exp=%b", rd_busy, 2'b00); end
        total++; if (rd[63:32] !== 32'h2020_2020) begin bad++; $display("FAIL flush_write got=%h exp=%h", rd[63:32], 32'h2020_2020); end
    endtask

    task automatic test_simultaneous();
        we = 1'b1; wa = 5'd6; wd = 32'h0000_0066; iss_v = 1'b1; iss_rd = 5'd8;
        pc_we = 1'b1; pc_in = 32'h0000_0300;
        tick();
        idle(); ra = {5'd8, 5'd6};
        #1;
        total++; if (rd[31:0] !== 32'h66) begin bad++; $display("FAIL simul_data got=%h exp=%h", rd[31:0], 32'h66); end
        total++; if (rd_busy !== 2'b10) begin bad++; $display("FAIL simul_busy got=%b exp=%b", rd_busy, 2'b10); end
        total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL simul_cnt got=%0d exp=%0d", busy_cnt, 1); end
        total++; if (pc_out !== 32'h300) begin bad++; $display("FAIL simul_pc got=%h exp=%h", pc_out, 32'h300); end
    endtask

    task automatic test_pc_reset();
        rst_n = 1'b0; pc_we = 1'b1; pc_in = 32'h0000_0100;
        we = 1'b1; wa = 5'd6; wd = 32'hFFFF_FFFF; iss_v = 1'b1; iss_rd = 5'd4;
        ra = {5'd4, 5'd6};
        tick();
        we = 1'b0; iss_v = 1'b0; rst_n = 1'b1;
        #1;
        total++; if (pc_out !== c_RPC) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_out, c_RPC); end
        total++; if (rd[31:0] !== 32'h0) begin bad++; $display("FAIL rst_regs got=%h exp=%h", rd[31:0], 32'h0); end
        total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=%0d", busy_cnt, 0); end
        total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL rst_busy got=%b exp=%b", rd_busy, 2'b00); end
        tick();
        pc_we = 1'b0; pc_in = 32'h0000_0200;
        #1;
        total++; if (pc_out !== 32'h100) begin bad++; $display("FAIL pc_load got=%h exp=%h", pc_out, 32'h100); end
        tick();
        total++; if (pc_out !== 32'h100) begin bad++; $display("FAIL pc_hold got=%h exp=%h", pc_out, 32'h100); end
    endtask

    initial begin
        rst_n = 1'b0; ra = '0; idle();
        test_reset();
        test_forward();
        test_x0();
        test_busy_clear();
        test_set_wins_flush();
        test_simultaneous();
        test_pc_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
